// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the 7-segment scan decoder.
package seg7_pkg;

  // Active-low segment patterns, bit0=a .. bit6=g (same table as the driver).
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low one-hot anodes, digit0 is the most significant digit.
  localparam logic [3:0] AN_D0  = 4'b0111;
  localparam logic [3:0] AN_D1  = 4'b1011;
  localparam logic [3:0] AN_D2  = 4'b1101;
  localparam logic [3:0] AN_D3  = 4'b1110;
  localparam logic [3:0] AN_OFF = 4'b1111;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_UNK   = 4'hE;

  typedef enum logic {SYNC, CAPT} state_t;

  // Result of one scanned digit slot.
  typedef struct packed {
    logic [3:0] bcd;
    logic       dot;
    logic       blank;
  } slot_t;

  // Map a locked segment pattern to BCD; dark pattern is blank, anything else unknown.
  function automatic logic [3:0] seg_to_bcd(input logic [6:0] s);
    logic [3:0] r;
    case (s)
      SEG_0:   r = 4'd0;
      SEG_1:   r = 4'd1;
      SEG_2:   r = 4'd2;
      SEG_3:   r = 4'd3;
      SEG_4:   r = 4'd4;
      SEG_5:   r = 4'd5;
      SEG_6:   r = 4'd6;
      SEG_7:   r = 4'd7;
      SEG_8:   r = 4'd8;
      SEG_9:   r = 4'd9;
      SEG_OFF: r = BCD_BLANK;
      default: r = BCD_UNK;
    endcase
    return r;
  endfunction

  // Anode pattern expected for a given slot index.
  function automatic logic [3:0] an_expected(input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = AN_D0;
      2'd1:    r = AN_D1;
      2'd2:    r = AN_D2;
      default: r = AN_D3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_slot_capture.sv
// Per-slot pattern qualifier: candidate tracking, stability count, lock and dot OR.
module seg7_slot_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_slot_start,
  input  logic [6:0] i_seg,
  input  logic       i_dp,
  output logic       o_locked,
  output logic [6:0] o_cand,
  output logic       o_dot
);

  localparam int unsigned CNT_W = 6;

  logic [CNT_W-1:0] r_cnt;
  logic             r_locked;
  logic [6:0]       r_cand;
  logic             r_dot;

  logic [CNT_W-1:0] w_cnt;
  logic             w_locked;
  logic [6:0]       w_cand;
  logic             w_dot;
  logic             w_lit;

  assign w_lit = (i_seg != SEG_OFF) || !i_dp;

  // Next slot state; a slot start clears first so the current sample opens the new slot.
  always_comb begin
    w_cnt    = r_cnt;
    w_locked = r_locked;
    w_cand   = r_cand;
    w_dot    = r_dot;
    if (i_slot_start) begin
      w_cnt    = '0;
      w_locked = 1'b0;
      w_cand   = SEG_OFF;
      w_dot    = 1'b0;
    end
    if (w_lit) begin
      w_dot = w_dot | ~i_dp;
      if (!w_locked) begin
        if ((w_cnt == '0) || (i_seg != w_cand)) begin
          w_cand = i_seg;
          w_cnt  = CNT_W'(1);
        end else begin
          w_cnt = w_cnt + CNT_W'(1);
        end
        if (w_cnt == CNT_W'(STABLE_CYC)) w_locked = 1'b1;
      end
    end
  end

  // Slot state registers, frozen while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_locked <= 1'b0;
      r_cand   <= SEG_OFF;
      r_dot    <= 1'b0;
    end else if (i_en) begin
      r_cnt    <= w_cnt;
      r_locked <= w_locked;
      r_cand   <= w_cand;
      r_dot    <= w_dot;
    end
  end

  assign o_locked = r_locked;
  assign o_cand   = r_cand;
  assign o_dot    = r_dot;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Loopback monitor that rebuilds the 4 displayed digits from the multiplexed display lines.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYC   = 8,
  parameter int unsigned SLOT_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic [3:0]  an,
  output logic [15:0] x,
  output logic [3:0]  x_dp,
  output logic [3:0]  blank,
  output logic        frame_vld,
  output logic        seq_err,
  output logic        code_err,
  output logic        stall
);

  localparam int unsigned STALL_W = 13;

  logic [6:0]         r_seg;
  logic               r_dp;
  logic [3:0]         r_an;
  logic [3:0]         r_an_last;
  state_t             r_state;
  logic [1:0]         r_idx;
  slot_t              r_shadow [4];
  logic [STALL_W-1:0] r_stall_cnt;

  state_t             w_state;
  logic [1:0]         w_idx;
  slot_t              w_shadow [4];
  logic [15:0]        w_x;
  logic [3:0]         w_x_dp;
  logic [3:0]         w_blank;
  logic               w_frame;
  logic               w_seq;
  logic               w_code;
  logic               w_an_chg;
  logic               w_timeout;
  logic               w_locked;
  logic [6:0]         w_cand;
  logic               w_dot;
  slot_t              w_slot_res;

  assign w_an_chg  = en && (r_an != r_an_last);
  assign w_timeout = en && !w_an_chg && (r_stall_cnt == STALL_W'(SLOT_TIMEOUT - 1));

  seg7_slot_capture #(
    .STABLE_CYC (STABLE_CYC)
  ) u_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (en),
    .i_slot_start (w_an_chg),
    .i_seg        (r_seg),
    .i_dp         (r_dp),
    .o_locked     (w_locked),
    .o_cand       (w_cand),
    .o_dot        (w_dot)
  );

  // Result of the slot that is closing on this anode change.
  always_comb begin
    w_slot_res.bcd   = w_locked ? seg_to_bcd(w_cand) : BCD_BLANK;
    w_slot_res.dot   = w_dot;
    w_slot_res.blank = !w_locked;
  end

  // Scan-order FSM next state, shadow update and frame commit.
  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_shadow = r_shadow;
    w_x      = x;
    w_x_dp   = x_dp;
    w_blank  = blank;
    w_frame  = 1'b0;
    w_seq    = 1'b0;
    w_code   = 1'b0;
    if (w_an_chg) begin
      case (r_state)
        SYNC: begin
          if (r_an == AN_D0) begin
            w_state = CAPT;
            w_idx   = 2'd0;
          end
        end
        CAPT: begin
          w_shadow[r_idx] = w_slot_res;
          if ((r_idx == 2'd3) && (r_an == AN_D0)) begin
            w_idx   = 2'd0;
            w_frame = 1'b1;
            w_x     = {w_shadow[0].bcd, w_shadow[1].bcd, w_shadow[2].bcd, w_shadow[3].bcd};
            w_x_dp  = {w_shadow[0].dot, w_shadow[1].dot, w_shadow[2].dot, w_shadow[3].dot};
            w_blank = {w_shadow[0].blank, w_shadow[1].blank, w_shadow[2].blank, w_shadow[3].blank};
            w_code  = (w_shadow[0].bcd == BCD_UNK) || (w_shadow[1].bcd == BCD_UNK) ||
                      (w_shadow[2].bcd == BCD_UNK) || (w_shadow[3].bcd == BCD_UNK);
          end else if ((r_idx != 2'd3) && (r_an == an_expected(r_idx + 2'd1))) begin
            w_idx = r_idx + 2'd1;
          end else if (r_an == AN_OFF) begin
            w_state = SYNC;
          end else begin
            w_seq = 1'b1;
            if (r_an == AN_D0) begin
              w_idx = 2'd0;
            end else begin
              w_state = SYNC;
            end
          end
        end
        default: w_state = SYNC;
      endcase
    end else if (w_timeout) begin
      w_state = SYNC;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SYNC;
      r_idx   <= 2'd0;
    end else if (en) begin
      r_state <= w_state;
      r_idx   <= w_idx;
    end
  end

  // Input capture, shadow, outputs and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg       <= SEG_OFF;
      r_dp        <= 1'b1;
      r_an        <= AN_OFF;
      r_an_last   <= AN_OFF;
      for (int i = 0; i < 4; i++) r_shadow[i] <= '{bcd: BCD_BLANK, dot: 1'b0, blank: 1'b1};
      r_stall_cnt <= '0;
      x           <= 16'hFFFF;
      x_dp        <= 4'h0;
      blank       <= 4'hF;
      frame_vld   <= 1'b0;
      seq_err     <= 1'b0;
      code_err    <= 1'b0;
      stall       <= 1'b0;
    end else begin
      frame_vld <= w_frame;
      seq_err   <= w_seq;
      code_err  <= w_code;
      if (en) begin
        r_seg     <= seg;
        r_dp      <= dp;
        r_an      <= an;
        r_an_last <= r_an;
        r_shadow  <= w_shadow;
        x         <= w_x;
        x_dp      <= w_x_dp;
        blank     <= w_blank;
        if (w_an_chg) begin
          r_stall_cnt <= '0;
          stall       <= 1'b0;
        end else begin
          if (r_stall_cnt != STALL_W'(SLOT_TIMEOUT)) r_stall_cnt <= r_stall_cnt + STALL_W'(1);
          if (w_timeout) stall <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder driven by a simple scan-driver model.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] x;
  logic [3:0]  x_dp;
  logic [3:0]  blank;
  logic        frame_vld;
  logic        seq_err;
  logic        code_err;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fv     = 0;
  int n_se     = 0;
  int n_ce     = 0;
  int n_cefv   = 0;
  int fv0, se0, ce0, cefv0;

  logic [6:0] g_seg [4];
  logic       g_dp  [4];
  int         g_lit [4];

  seg7_scan_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .x         (x),
    .x_dp      (x_dp),
    .blank     (blank),
    .frame_vld (frame_vld),
    .seq_err   (seq_err),
    .code_err  (code_err),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_vld) n_fv++;
    if (seq_err) n_se++;
    if (code_err) n_ce++;
    if (code_err && frame_vld) n_cefv++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    fv0 = n_fv; se0 = n_se; ce0 = n_ce; cefv0 = n_cefv;
  endtask

  task automatic idle(input int n);
    an = AN_OFF; seg = SEG_OFF; dp = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] r;
    case (d)
      0:       r = AN_D0;
      1:       r = AN_D1;
      2:       r = AN_D2;
      default: r = AN_D3;
    endcase
    return r;
  endfunction

  // One anode slot: pre blank cycles, lit cycles of the pattern, blanks to fill t.
  task automatic drive_slot(input logic [3:0] a, input logic [6:0] s, input logic d,
                            input int lit, input int t, input int pre);
    for (int c = 0; c < t; c++) begin
      an = a;
      if (c >= pre && c < pre + lit) begin seg = s; dp = d; end
      else begin seg = SEG_OFF; dp = 1'b1; end
      @(posedge clk); #1;
    end
  endtask

  // dots: active-high dot mask, bit3 = digit0.
  task automatic set_digits(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dots, input int lit);
    g_seg[0] = s0; g_seg[1] = s1; g_seg[2] = s2; g_seg[3] = s3;
    for (int i = 0; i < 4; i++) begin
      g_dp[i]  = ~dots[3-i];
      g_lit[i] = lit;
    end
  endtask

  task automatic scan(input int frames, input int t, input int pre);
    idle(4);
    for (int f = 0; f < frames; f++)
      for (int d = 0; d < 4; d++) drive_slot(an_of(d), g_seg[d], g_dp[d], g_lit[d], t, pre);
    idle(8);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; an = AN_OFF; seg = SEG_OFF; dp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(x), 32'hFFFF);
    check("rst_x_dp", 32'(x_dp), 32'h0);
    check("rst_blank", 32'(blank), 32'hF);
    check("rst_pulses", 32'({frame_vld, seq_err, code_err}), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    rst_n = 1'b1;
    idle(4);

    // Full-rate scan of "1234" with 32-cycle anti-ghost blanks.
    snap();
    set_digits(SEG_1, SEG_2, SEG_3, SEG_4, 4'b0000, 960);
    scan(2, 1024, 32);
    check("n1234_fv", 32'(n_fv - fv0), 32'd1);
    check("n1234_x", 32'(x), 32'h1234);
    check("n1234_blank", 32'(blank), 32'h0);
    check("n1234_x_dp", 32'(x_dp), 32'h0);
    check("n1234_errs", 32'((n_se - se0) + (n_ce - ce0)), 32'd0);

    // Dimmed display with a dot on digit1.
    snap();
    set_digits(SEG_9, SEG_0, SEG_5, SEG_7, 4'b0100, 40);
    scan(2, 128, 44);
    check("dim_fv", 32'(n_fv - fv0), 32'd1);
    check("dim_x", 32'(x), 32'h9057);
    check("dim_x_dp", 32'(x_dp), 32'b0100);

    // Digit2 lit for fewer cycles than needed to lock.
    snap();
    set_digits(SEG_1, SEG_2, SEG_3, SEG_4, 4'b0000, 56);
    g_lit[2] = 5;
    scan(2, 64, 4);
    check("short_x", 32'(x), 32'h12F4);
    check("short_blank", 32'(blank), 32'b0010);

    // Dark digit with only the dot lit decodes blank but is not marked blank.
    snap();
    set_digits(SEG_1, SEG_2, SEG_3, SEG_OFF, 4'b0001, 56);
    scan(2, 64, 4);
    check("dponly_x", 32'(x), 32'h123F);
    check("dponly_blank", 32'(blank), 32'h0);
    check("dponly_x_dp", 32'(x_dp), 32'b0001);

    // Skipped anode: 0111, 1011, 1110.
    snap();
    idle(4);
    drive_slot(AN_D0, SEG_1, 1'b1, 56, 64, 4);
    drive_slot(AN_D1, SEG_2, 1'b1, 56, 64, 4);
    drive_slot(AN_D3, SEG_4, 1'b1, 56, 64, 4);
    idle(8);
    check("seq_se", 32'(n_se - se0), 32'd1);
    check("seq_fv", 32'(n_fv - fv0), 32'd0);
    check("seq_x_hold", 32'(x), 32'h123F);

    // Unknown segment pattern on digit1.
    snap();
    set_digits(SEG_5, 7'h2A, SEG_6, SEG_7, 4'b0000, 56);
    scan(2, 64, 4);
    check("code_x", 32'(x), 32'h5E67);
    check("code_ce", 32'(n_ce - ce0), 32'd1);
    check("code_ce_with_fv", 32'(n_cefv - cefv0), 32'd1);

    // Stall: hold digit1 anode well past the timeout.
    snap();
    idle(4);
    drive_slot(AN_D0, SEG_1, 1'b1, 56, 64, 4);
    an = AN_D1; seg = SEG_2; dp = 1'b1;
    repeat (4097) begin @(posedge clk); #1; end
    check("stall_before", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("stall_at_timeout", 32'(stall), 32'h1);
    repeat (5000 - 4098) begin @(posedge clk); #1; end
    check("stall_held", 32'(stall), 32'h1);
    drive_slot(AN_D3, SEG_4, 1'b1, 56, 64, 4);
    check("stall_cleared", 32'(stall), 32'h0);
    check("stall_resync_no_se", 32'(n_se - se0), 32'd0);
    set_digits(SEG_8, SEG_7, SEG_6, SEG_5, 4'b0000, 56);
    scan(2, 64, 4);
    check("resume_fv", 32'(n_fv - fv0), 32'd1);
    check("resume_x", 32'(x), 32'h8765);

    // Disabled: a full scan must leave everything untouched.
    snap();
    en = 1'b0;
    set_digits(SEG_1, SEG_1, SEG_1, SEG_1, 4'b1111, 56);
    scan(2, 64, 4);
    check("en0_fv", 32'(n_fv - fv0), 32'd0);
    check("en0_x", 32'(x), 32'h8765);
    check("en0_x_dp", 32'(x_dp), 32'h0);
    en = 1'b1;
    idle(4);

    // Reset in the middle of digit1 of a frame.
    snap();
    idle(4);
    drive_slot(AN_D0, SEG_3, 1'b1, 56, 64, 4);
    drive_slot(AN_D1, SEG_4, 1'b1, 56, 20, 4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_x", 32'(x), 32'hFFFF);
    check("mid_rst_blank", 32'(blank), 32'hF);
    check("mid_rst_stall_pulses", 32'({stall, frame_vld, seq_err, code_err}), 32'h0);
    rst_n = 1'b1;
    drive_slot(AN_D1, SEG_4, 1'b1, 40, 44, 0);
    drive_slot(AN_D2, SEG_5, 1'b1, 56, 64, 4);
    drive_slot(AN_D3, SEG_6, 1'b1, 56, 64, 4);
    drive_slot(AN_D0, SEG_7, 1'b1, 56, 64, 4);
    idle(8);
    check("post_rst_fv", 32'(n_fv - fv0), 32'd0);
    check("post_rst_x", 32'(x), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
